// File: rtl/bus_mem_responder.sv
// Memory-side responder for the addr/dat/wrt/rd processor bus: RAM, out_port mirror, error flag, access counters.
// Define MEM_CLEAR_EN to zero the RAM with a one-word-per-cycle sweep after every reset.
module bus_mem_responder #(
    parameter int                unsigned ADDR_W        = 8,
    parameter int                unsigned DATA_W        = 8,
    parameter logic [ADDR_W-1:0]          OUT_PORT_ADDR = '1,
    parameter int                unsigned CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] dat,
    input  logic              wrt,
    input  logic              rd,
    output logic              busy,
    output logic              bus_err,
    output logic [DATA_W-1:0] out_port,
    output logic              out_strobe,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    typedef enum logic [2:0] {CLEAR, IDLE, READ, WRITE, ERR} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] last_addr;
    logic              rd_ok;
    logic              wr_ok;
    logic              active;
    logic              count_rd;
    logic              count_wr;

    assign rd_ok  = rd && !wrt;
    assign wr_ok  = wrt && !rd;
    assign active = (state != CLEAR);

    // Gating with rst releases the bus the instant reset is asserted.
    assign dat = (rd_ok && active && !rst) ? mem[addr] : 'z;

    always_comb begin
        count_rd = 1'b0;
        count_wr = 1'b0;
        if (state == IDLE) begin
            count_rd = rd_ok;
            count_wr = wr_ok;
        end else if (state == READ) begin
            count_rd = rd_ok && (addr != last_addr);
        end else if (state == WRITE) begin
            count_wr = wr_ok && (addr != last_addr);
        end
    end

`ifdef MEM_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr;

    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[clr_addr] <= '0;
        else if (wr_ok)
            mem[addr] <= dat;
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clk) begin
        if (wr_ok && active)
            mem[addr] <= dat;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef MEM_CLEAR_EN
            state    <= CLEAR;
            busy     <= 1'b1;
            clr_addr <= '0;
`else
            state    <= IDLE;
`endif
            bus_err    <= 1'b0;
            out_port   <= '0;
            out_strobe <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
            last_addr  <= '0;
        end else begin
            last_addr  <= addr;
            out_strobe <= count_wr && (addr == OUT_PORT_ADDR);

            if (count_rd && rd_count != '1)
                rd_count <= rd_count + 1'b1;
            if (count_wr && wr_count != '1)
                wr_count <= wr_count + 1'b1;
            if (wr_ok && active && addr == OUT_PORT_ADDR)
                out_port <= dat;

            case (state)
`ifdef MEM_CLEAR_EN
                CLEAR: begin
                    if (rd || wrt)
                        bus_err <= 1'b1;
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == '1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
`endif
                IDLE: begin
                    if (rd && wrt) begin
                        state   <= ERR;
                        bus_err <= 1'b1;
                    end else if (rd) begin
                        state <= READ;
                    end else if (wrt) begin
                        state <= WRITE;
                    end
                end
                READ: begin
                    if (rd && wrt) begin
                        state   <= ERR;
                        bus_err <= 1'b1;
                    end else if (!rd) begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    if (rd && wrt) begin
                        state   <= ERR;
                        bus_err <= 1'b1;
                    end else if (!wrt) begin
                        state <= IDLE;
                    end
                end
                ERR: begin
                    bus_err <= 1'b1;
                    if (!rd && !wrt)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder; dat has pull-ups so a released bus reads 8'hFF.
// Define MEM_CLEAR_EN for both files to exercise the clear sweep.
module tb_bus_mem_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wrt = 1'b0;
    logic       rd  = 1'b0;
    logic       drv = 1'b0;
    logic [7:0] addr   = '0;
    logic [7:0] tb_dat = '0;
    wire  [7:0] dat;
    logic       busy;
    logic       bus_err;
    logic [7:0] out_port;
    logic       out_strobe;
    logic [3:0] rd_count;
    logic [3:0] wr_count;

    int tests = 0;
    int fails = 0;

`ifdef MEM_CLEAR_EN
    localparam logic [7:0] EXP10_AFTER_RST = 8'h00;
    localparam logic       BUSY_RST        = 1'b1;
`else
    localparam logic [7:0] EXP10_AFTER_RST = 8'h3C;
    localparam logic       BUSY_RST        = 1'b0;
`endif

    assign dat = drv ? tb_dat : 'z;

    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (dat[i]);
    end

    always #5 clk = ~clk;

    bus_mem_responder #(
        .ADDR_W       (8),
        .DATA_W       (8),
        .OUT_PORT_ADDR(8'hFF),
        .CNT_W        (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .dat       (dat),
        .wrt       (wrt),
        .rd        (rd),
        .busy      (busy),
        .bus_err   (bus_err),
        .out_port  (out_port),
        .out_strobe(out_strobe),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic r, input logic w, input logic [7:0] a,
                       input logic d, input logic [7:0] v);
        rd = r; wrt = w; addr = a; drv = d; tb_dat = v;
        #1;
    endtask

    task automatic wait_sweep(input logic probe);
`ifdef MEM_CLEAR_EN
        int n = 0;
        while (busy && n < 400) begin
            if (probe && n == 100) begin
                bus(1, 0, 8'h10, 0, 8'h00);
                check("sweep_dat_z", dat, 8'hFF);
            end else if (probe && n == 101) begin
                bus(0, 0, 8'h00, 0, 8'h00);
            end
            cyc();
            n++;
        end
        check("sweep_len", n, 256);
        check("sweep_busy_done", busy, 1'b0);
        if (probe)
            check("sweep_bus_err", bus_err, 1'b1);
`else
        if (probe)
            check("no_sweep_busy", busy, 1'b0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rd = 1'b1;
        #12;
        check("rst_dat_z", dat, 8'hFF);
        check("rst_busy", busy, BUSY_RST);
        check("rst_bus_err", bus_err, 1'b0);
        check("rst_out_port", out_port, 8'h00);
        check("rst_strobe", out_strobe, 1'b0);
        check("rst_rd_count", rd_count, 4'd0);
        check("rst_wr_count", wr_count, 4'd0);
        rd  = 1'b0;
        rst = 1'b0;
        wait_sweep(0);

        // write 3C @10 for two cycles, then read it back
        bus(0, 1, 8'h10, 1, 8'h3C); cyc(); cyc();
        bus(0, 0, 8'h00, 0, 8'h00); cyc();
        bus(1, 0, 8'h10, 0, 8'h00);
        check("t1_rd_dat", dat, 8'h3C);
        cyc();
        check("t1_rd_count", rd_count, 4'd1);
        check("t1_wr_count", wr_count, 4'd1);
        check("t1_bus_err", bus_err, 1'b0);
        bus(0, 0, 8'h00, 0, 8'h00); cyc();

        // out_port mirror, strobe only for the counted edge
        bus(0, 1, 8'hFF, 1, 8'hA5); cyc();
        check("t2_out_port", out_port, 8'hA5);
        check("t2_strobe_on", out_strobe, 1'b1);
        check("t2_wr_count", wr_count, 4'd2);
        cyc();
        check("t2_strobe_off", out_strobe, 1'b0);
        bus(0, 0, 8'h00, 0, 8'h00); cyc();
        bus(1, 0, 8'hFF, 0, 8'h00);
        check("t2_rd_dat", dat, 8'hA5);
        cyc();
        check("t2_rd_count", rd_count, 4'd2);
        bus(0, 0, 8'h00, 0, 8'h00); cyc();

        // rd && wrt collision
        bus(0, 1, 8'h20, 1, 8'h11); cyc();
        bus(0, 0, 8'h00, 0, 8'h00); cyc();
        check("t3_wr_count", wr_count, 4'd3);
        bus(1, 1, 8'h20, 0, 8'h00);
        check("t3_dat_z", dat, 8'hFF);
        cyc();
        check("t3_bus_err", bus_err, 1'b1);
        bus(0, 0, 8'h00, 0, 8'h00); cyc();
        check("t3_bus_err_sticky", bus_err, 1'b1);
        bus(1, 0, 8'h20, 0, 8'h00);
        check("t3_ram_unchanged", dat, 8'h11);
        cyc();
        bus(0, 0, 8'h00, 0, 8'h00); cyc();
        bus(1, 0, 8'h10, 0, 8'h00);
        check("t3_rd_after_err", dat, 8'h3C);
        cyc();
        check("t3_rd_count", rd_count, 4'd4);
        check("t3_wr_count_hold", wr_count, 4'd3);
        bus(0, 0, 8'h00, 0, 8'h00); cyc();

        // address stepping within one held access
        for (int i = 0; i < 3; i++) begin
            bus(0, 1, 8'(i), 1, 8'(8'h40 + i)); cyc();
        end
        check("t4_wr_count", wr_count, 4'd6);
        bus(0, 0, 8'h00, 0, 8'h00); cyc();
        for (int i = 0; i < 3; i++) begin
            bus(1, 0, 8'(i), 0, 8'h00);
            check($sformatf("t4_rd_dat_%0d", i), dat, 32'(8'h40 + i));
            cyc();
        end
        check("t4_rd_count", rd_count, 4'd7);
        for (int i = 3; i < 23; i++) begin
            bus(1, 0, 8'(i), 0, 8'h00); cyc();
        end
        check("rd_count_sat", rd_count, 4'd15);
        check("wr_count_hold", wr_count, 4'd6);
        bus(0, 0, 8'h00, 0, 8'h00); cyc();

        // reset in the middle of a write, then in the middle of a read
        bus(0, 1, 8'h30, 1, 8'h77); cyc();
        check("t5_wr_count", wr_count, 4'd7);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_wr_count", wr_count, 4'd0);
        check("t5_rst_rd_count", rd_count, 4'd0);
        check("t5_rst_out_port", out_port, 8'h00);
        check("t5_rst_bus_err", bus_err, 1'b0);
        bus(0, 0, 8'h00, 0, 8'h00);
        #3 rst = 1'b0;
        wait_sweep(0);
        cyc();
        bus(1, 0, 8'h10, 0, 8'h00);
        check("t5_ram_kept", dat, EXP10_AFTER_RST);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_dat_z", dat, 8'hFF);
        rd = 1'b0;
        #3 rst = 1'b0;

        wait_sweep(1);
        cyc();
        bus(1, 0, 8'h10, 0, 8'h00);
        check("t6_rd_after_rst", dat, EXP10_AFTER_RST);
        cyc();
        check("t6_rd_count", rd_count, 4'd1);
        bus(0, 0, 8'h00, 0, 8'h00); cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
